// File: rtl/bus_master_ctrl.sv
// ---------------------------------------------------------------------------
// bus_master_ctrl
//
// Burst master for a multiplexed address/data bus. The user side issues one
// request per transaction. The request carries a direction, a start address
// and, for writes, all write beats at once. The master puts the address on
// the bus for one cycle with AddrValid high. It then drives BURST write
// beats, or samples BURST read beats from the slave. It finishes with one
// turnaround cycle that pulses done. The slave increments the address, not
// the master.
//
// Parameters
//   DATAWIDTH  bus / beat width in bits
//   BURST      data beats per transaction
//
// Ports
//   clk        single clock, rising-edge active
//   resetN     asynchronous active-low reset
//   req        user request, accepted on a rising edge with ready=1
//   reqRw      request direction: 1=read burst, 0=write burst
//   reqAddr    start address: [15:12] page, [11:0] word offset
//   wrData     write beats, beat k at [k*DATAWIDTH +: DATAWIDTH]
//   ready      high only while idle
//   rdData     registered read beat, holds its value between strobes
//   rdValid    one-cycle strobe qualifying rdData
//   rdBeat     beat index of the value on rdData
//   done       one-cycle pulse in the turnaround cycle
//   AddrValid  main-bus address strobe
//   rw         main-bus direction, 1=read
//   AddrData   multiplexed address/data bus, released to 'z when not driven
//
// States
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | ready for a request, bus released, rw=1
//   ST_ADDR   | one cycle: latched address on bus, AddrValid=1
//   ST_WDATA  | BURST cycles: master drives write beat[cnt]
//   ST_RDATA  | BURST cycles: slave drives, master samples beat[cnt]
//   ST_TURN   | one cycle: bus released, done=1, back to idle
// ---------------------------------------------------------------------------
module bus_master_ctrl #(
    parameter int DATAWIDTH = 16,
    parameter int BURST     = 4
) (
    input  logic                                         clk,
    input  logic                                         resetN,
    input  logic                                         req,
    input  logic                                         reqRw,
    input  logic [DATAWIDTH-1:0]                         reqAddr,
    input  logic [BURST*DATAWIDTH-1:0]                   wrData,
    output logic                                         ready,
    output logic [DATAWIDTH-1:0]                         rdData,
    output logic                                         rdValid,
    output logic [((BURST > 1) ? $clog2(BURST) : 1)-1:0] rdBeat,
    output logic                                         done,
    output logic                                         AddrValid,
    output logic                                         rw,
    inout  wire  [DATAWIDTH-1:0]                         AddrData
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_TURN  = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    // Request snapshot. Later changes on the request inputs cannot
    // disturb a burst that is already running.
    logic [DATAWIDTH-1:0] addr_lat;
    logic                 rw_lat;
    logic [DATAWIDTH-1:0] wr_beats [BURST];

    logic [CW-1:0]        cnt_q;
    logic                 last_beat;
    logic                 accept;

    // Bus driver controls from the output decode
    logic                 drive_en;
    logic [DATAWIDTH-1:0] bus_out;

    assign accept    = (state_q == ST_IDLE) && req;
    assign last_beat = (cnt_q == LAST_BEAT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                state_d = rw_lat ? ST_RDATA : ST_WDATA;
            end
            ST_WDATA, ST_RDATA: begin
                if (last_beat) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore, from state only)
    // ------------------------------------------------------------------
    always_comb begin
        ready     = 1'b0;
        AddrValid = 1'b0;
        rw        = 1'b1;
        done      = 1'b0;
        drive_en  = 1'b0;
        bus_out   = '0;
        unique case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_ADDR: begin
                AddrValid = 1'b1;
                rw        = rw_lat;
                drive_en  = 1'b1;
                bus_out   = addr_lat;
            end
            ST_WDATA: begin
                rw       = 1'b0;
                drive_en = 1'b1;
                bus_out  = wr_beats[cnt_q];
            end
            ST_RDATA: begin
                rw = 1'b1;
            end
            ST_TURN: begin
                done = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // The master drives only in ADDR and WDATA. RDATA and TURN leave the
    // bus free, so the slave's read drive can never overlap it. This
    // decodes from state_q, so an asynchronous reset releases the bus at
    // once.
    assign AddrData = drive_en ? bus_out : {DATAWIDTH{1'bz}};

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            addr_lat <= '0;
            rw_lat   <= 1'b1;
            for (int k = 0; k < BURST; k++) begin
                wr_beats[k] <= '0;
            end
        end else if (accept) begin
            addr_lat <= reqAddr;
            rw_lat   <= reqRw;
            for (int k = 0; k < BURST; k++) begin
                wr_beats[k] <= wrData[k*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat counter. It clears in ADDR and stops at the last beat instead
    // of wrapping. The state machine leaves the data phase on that beat.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    cnt_q <= '0;
                end
                ST_WDATA, ST_RDATA: begin
                    if (!last_beat) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read capture. Each RDATA edge samples the bus. The beat shows up on
    // rdData in the following cycle, together with its index and a
    // single-cycle rdValid. rdData keeps the last beat until the next
    // capture.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rdData  <= '0;
            rdValid <= 1'b0;
            rdBeat  <= '0;
        end else begin
            rdValid <= (state_q == ST_RDATA);
            if (state_q == ST_RDATA) begin
                rdData <= AddrData;
                rdBeat <= cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_bus_master_ctrl.sv
module tb_bus_master_ctrl;

    localparam int DW = 16;
    localparam int NB = 4;
    localparam int CW = $clog2(NB);
    localparam int PERIOD = NB + 3;   // transaction length plus the idle cycle that accepts the next request

    logic              clk     = 1'b0;
    logic              resetN  = 1'b1;
    logic              req     = 1'b0;
    logic              reqRw   = 1'b0;
    logic [DW-1:0]     reqAddr = '0;
    logic [NB*DW-1:0]  wrData  = '0;
    logic              ready;
    logic [DW-1:0]     rdData;
    logic              rdValid;
    logic [CW-1:0]     rdBeat;
    logic              done;
    logic              AddrValid;
    logic              rw;
    wire  [DW-1:0]     AddrData;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    bus_master_ctrl #(.DATAWIDTH(DW), .BURST(NB)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .req       (req),
        .reqRw     (reqRw),
        .reqAddr   (reqAddr),
        .wrData    (wrData),
        .ready     (ready),
        .rdData    (rdData),
        .rdValid   (rdValid),
        .rdBeat    (rdBeat),
        .done      (done),
        .AddrValid (AddrValid),
        .rw        (rw),
        .AddrData  (AddrData)
    );

    // Slave memory on page 2 only. It increments the address per beat and
    // drives read beats only in the BURST cycles after the address phase.
    logic [DW-1:0] mem [4096];
    logic          slv_act;
    logic          slv_rd;
    logic          slv_drive;
    logic [DW-1:0] slv_data;
    logic [11:0]   slv_off;
    int            slv_beat;

    assign AddrData = slv_drive ? slv_data : {DW{1'bz}};

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            slv_act   <= 1'b0;
            slv_rd    <= 1'b0;
            slv_drive <= 1'b0;
            slv_data  <= '0;
            slv_off   <= '0;
            slv_beat  <= 0;
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
        end else if (AddrValid) begin
            slv_act   <= (AddrData[15:12] == 4'h2);
            slv_rd    <= rw;
            slv_off   <= AddrData[11:0];
            slv_beat  <= 0;
            slv_drive <= rw && (AddrData[15:12] == 4'h2);
            slv_data  <= mem[AddrData[11:0]];
        end else if (slv_act) begin
            if (!slv_rd) mem[slv_off + 12'(slv_beat)] <= AddrData;
            if (slv_beat == NB - 1) begin
                slv_act   <= 1'b0;
                slv_drive <= 1'b0;
            end else begin
                slv_beat <= slv_beat + 1;
                slv_data <= mem[slv_off + 12'(slv_beat + 1)];
            end
        end
    end

    // Reference model: what page-2 memory should contain after the writes
    // issued so far.
    logic [DW-1:0] model_mem [4096];

    // One full transaction. It starts at a negedge while the DUT is idle
    // and ends at the negedge of the following idle cycle with req=0. With
    // junk=1 the request inputs are scrambled while busy, and req is held
    // high in the turnaround cycle.
    task automatic run_txn(input logic dir, input logic [DW-1:0] addr,
                           input logic [NB*DW-1:0] wd, input bit junk);
        logic [DW-1:0] exp_rd [NB];
        bit on_page;
        int k;
        on_page = (addr[15:12] == 4'h2);
        for (int j = 0; j < NB; j++) exp_rd[j] = model_mem[12'(int'(addr[11:0]) + j)];
        cmp_cnt++;
        if (ready !== 1'b1) begin err_cnt++; $display("FAIL idle_ready_before: got %b want 1", ready); end
        req = 1'b1; reqRw = dir; reqAddr = addr; wrData = wd;
        for (int c = 1; c <= NB + 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cmp_cnt++;
                if ({AddrValid, rw, ready, done, rdValid} !== {1'b1, dir, 1'b0, 1'b0, 1'b0}) begin
                    err_cnt++; $display("FAIL addr_ctl: got av/rw/rdy/done/rv=%b want %b",
                        {AddrValid, rw, ready, done, rdValid}, {1'b1, dir, 3'b000});
                end
                cmp_cnt++;
                if (AddrData !== addr) begin err_cnt++; $display("FAIL addr_bus: got %h want %h", AddrData, addr); end
            end else if (c <= NB + 1) begin
                k = c - 2;
                cmp_cnt++;
                if ({AddrValid, rw, ready, done} !== {1'b0, dir, 1'b0, 1'b0}) begin
                    err_cnt++; $display("FAIL data_ctl beat %0d: got av/rw/rdy/done=%b want %b",
                        k, {AddrValid, rw, ready, done}, {1'b0, dir, 2'b00});
                end
                if (!dir) begin
                    cmp_cnt++;
                    if (AddrData !== wd[k*DW +: DW]) begin
                        err_cnt++; $display("FAIL wr_beat %0d: got %h want %h", k, AddrData, wd[k*DW +: DW]);
                    end
                end else begin
                    cmp_cnt++;
                    if (rdValid !== logic'(k > 0)) begin
                        err_cnt++; $display("FAIL rd_valid beat %0d: got %b want %b", k, rdValid, (k > 0));
                    end
                    if (k > 0) begin
                        cmp_cnt++;
                        if (rdBeat !== CW'(k - 1)) begin
                            err_cnt++; $display("FAIL rd_beat_idx: got %0d want %0d", rdBeat, k - 1);
                        end
                        if (on_page) begin
                            cmp_cnt++;
                            if (rdData !== exp_rd[k-1]) begin
                                err_cnt++; $display("FAIL rd_data beat %0d: got %h want %h", k - 1, rdData, exp_rd[k-1]);
                            end
                        end
                    end
                    if (on_page) begin
                        cmp_cnt++;
                        if (AddrData !== exp_rd[k]) begin
                            err_cnt++; $display("FAIL rd_bus beat %0d: got %h want %h", k, AddrData, exp_rd[k]);
                        end
                    end
                end
            end else if (c == NB + 2) begin
                cmp_cnt++;
                if ({AddrValid, rw, ready, done, rdValid} !== {1'b0, 1'b1, 1'b0, 1'b1, dir}) begin
                    err_cnt++; $display("FAIL turn_ctl: got av/rw/rdy/done/rv=%b want %b",
                        {AddrValid, rw, ready, done, rdValid}, {4'b0101, dir});
                end
                if (dir) begin
                    cmp_cnt++;
                    if (rdBeat !== CW'(NB - 1)) begin
                        err_cnt++; $display("FAIL turn_rd_beat: got %0d want %0d", rdBeat, NB - 1);
                    end
                    if (on_page) begin
                        cmp_cnt++;
                        if (rdData !== exp_rd[NB-1]) begin
                            err_cnt++; $display("FAIL turn_rd_data: got %h want %h", rdData, exp_rd[NB-1]);
                        end
                    end
                end
            end else begin
                cmp_cnt++;
                if ({AddrValid, rw, ready, done, rdValid} !== 5'b01100) begin
                    err_cnt++; $display("FAIL back_idle_ctl: got av/rw/rdy/done/rv=%b want 01100",
                        {AddrValid, rw, ready, done, rdValid});
                end
                if (dir && on_page) begin
                    cmp_cnt++;
                    if (rdData !== exp_rd[NB-1]) begin
                        err_cnt++; $display("FAIL rd_data_hold: got %h want %h", rdData, exp_rd[NB-1]);
                    end
                end
            end
            if (c <= NB + 1) begin
                if (junk) begin
                    req     = 1'($urandom_range(0, 1));
                    reqRw   = 1'($urandom_range(0, 1));
                    reqAddr = DW'($urandom);
                    wrData  = {$urandom, $urandom};
                end else begin
                    req = 1'b0;
                end
            end else if (c == NB + 2) begin
                req = junk;
            end else begin
                req = 1'b0;
            end
        end
        if (!dir && on_page) begin
            for (int j = 0; j < NB; j++) model_mem[12'(int'(addr[11:0]) + j)] = wd[j*DW +: DW];
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #1;
        cmp_cnt++;
        if ({ready, AddrValid, rw, rdValid, done} !== 5'b10100) begin
            err_cnt++; $display("FAIL reset_ctl: got rdy/av/rw/rv/done=%b want 10100",
                {ready, AddrValid, rw, rdValid, done});
        end
        cmp_cnt++;
        if (rdData !== '0) begin err_cnt++; $display("FAIL reset_rd_data: got %h want 0", rdData); end
        cmp_cnt++;
        if (rdBeat !== '0) begin err_cnt++; $display("FAIL reset_rd_beat: got %0d want 0", rdBeat); end
        for (int i = 0; i < 4096; i++) model_mem[i] = '0;
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        // The request arrives with the reset release and must be taken at
        // the very next rising edge.
        run_txn(1'b0, 16'h2100, {$urandom, $urandom}, 1'b0);
    endtask

    task automatic test_write_burst();
        logic [DW-1:0] got;
        run_txn(1'b0, 16'h2010, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, 1'b0);
        for (int k = 0; k < NB; k++) begin
            got = mem[12'h010 + 12'(k)];
            cmp_cnt++;
            if (got !== 16'(16'h00A0 + k)) begin
                err_cnt++; $display("FAIL wr_mem word %0d: got %h want %h", k, got, 16'(16'h00A0 + k));
            end
        end
    endtask

    task automatic test_read_burst();
        run_txn(1'b0, 16'h2010, {16'h0044, 16'h0033, 16'h0022, 16'h0011}, 1'b0);
        run_txn(1'b1, 16'h2010, '0, 1'b0);
    endtask

    task automatic test_wrong_page();
        run_txn(1'b1, 16'hF000, '0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [NB*DW-1:0] wd;
        wd = {$urandom, $urandom};
        req = 1'b1; reqRw = 1'b0; reqAddr = 16'h2020; wrData = wd;
        for (int c = 1; c <= 3 * PERIOD; c++) begin
            @(negedge clk);
            cmp_cnt++;
            if (AddrValid !== logic'((c - 1) % PERIOD == 0)) begin
                err_cnt++; $display("FAIL b2b_addr_valid cycle %0d: got %b want %b", c, AddrValid, ((c - 1) % PERIOD == 0));
            end
            cmp_cnt++;
            if (done !== logic'((c - 1) % PERIOD == NB + 1)) begin
                err_cnt++; $display("FAIL b2b_done cycle %0d: got %b want %b", c, done, ((c - 1) % PERIOD == NB + 1));
            end
        end
        req = 1'b0;
        for (int j = 0; j < NB; j++) model_mem[12'h020 + 12'(j)] = wd[j*DW +: DW];
    endtask

    task automatic test_random();
        logic          dir;
        logic [DW-1:0] addr;
        for (int t = 0; t < 24; t++) begin
            dir  = 1'($urandom_range(0, 1));
            addr = {(($urandom_range(0, 5) == 0) ? 4'hF : 4'h2), 12'($urandom)};
            run_txn(dir, addr, {$urandom, $urandom}, 1'b1);
        end
    endtask

    task automatic test_reset_mid_read();
        req = 1'b1; reqRw = 1'b1; reqAddr = 16'h2010; wrData = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            req = 1'b0;
        end
        cmp_cnt++;
        if ({rdValid, rdBeat} !== {1'b1, CW'(1)}) begin
            err_cnt++; $display("FAIL midread_pre: got rv/beat=%b/%0d want 1/1", rdValid, rdBeat);
        end
        #2 resetN = 1'b0;
        #1;
        cmp_cnt++;
        if ({ready, AddrValid, rw, rdValid, done} !== 5'b10100) begin
            err_cnt++; $display("FAIL midread_reset_ctl: got rdy/av/rw/rv/done=%b want 10100",
                {ready, AddrValid, rw, rdValid, done});
        end
        cmp_cnt++;
        if (rdData !== '0) begin err_cnt++; $display("FAIL midread_reset_data: got %h want 0", rdData); end
        for (int i = 0; i < 4096; i++) model_mem[i] = '0;
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        for (int c = 1; c <= PERIOD; c++) begin
            @(negedge clk);
            cmp_cnt++;
            if ({ready, rdValid, done, AddrValid} !== 4'b1000) begin
                err_cnt++; $display("FAIL after_abort cycle %0d: got rdy/rv/done/av=%b want 1000",
                    c, {ready, rdValid, done, AddrValid});
            end
        end
        run_txn(1'b1, 16'h2010, '0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrong_page();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
